pipe_hazard_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core. It merges per-stage stall

---
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 94 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline hazard controller and the core's
// stage registers: stall requests and multi-cycle/flush inputs going in,
// per-stage holds, flush/redirect and the perf counter coming out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
);
    logic [STAGES-1:0] stallreq;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              flush_req;
    logic [PC_W-1:0]   flush_pc;

    logic [STAGES-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic              mc_busy;
    logic [PERF_W-1:0] stall_cycles;

    // Pipeline side: raises requests, consumes holds and redirects.
    modport master (
        output stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, mc_busy, stall_cycles
    );

    // Controller side.
    modport slave (
        input  stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, mc_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Merges per-stage stall requests into a thermometer hold bus
// (bit0=PC .. bit5=WB), times multi-cycle EX operations, issues registered
// flushes with a redirect PC and counts stalled cycles (saturating).
module pipe_hazard_ctrl #(
    parameter int unsigned STAGES   = 6,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned MC_STAGE = 3,
    parameter int unsigned PERF_W   = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    logic [CNT_W-1:0]  mc_cnt;
    logic              flush_q;
    logic [PC_W-1:0]   new_pc_q;
    logic [PERF_W-1:0] perf_q;

    logic              mc_req;
    logic              mc_accept;
    logic              busy;
    logic [STAGES-1:0] eff;
    logic [STAGES-1:0] stall_c;
    logic              acc;

    // Multi-cycle request qualification; a pending flush suppresses new ops.
    always_comb begin
        mc_req    = bus.mc_start && (bus.mc_cycles != '0) && !flush_q;
        mc_accept = mc_req && (mc_cnt == '0);
        busy      = !rst && ((mc_cnt != '0) || mc_req);
    end

    // Merge requests and extend to a thermometer: the deepest stalled stage
    // holds every stage upstream of it. Flush overrides all stalls.
    always_comb begin
        eff     = bus.stallreq | (STAGES'(busy) << MC_STAGE);
        acc     = 1'b0;
        stall_c = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            acc = acc | eff[STAGES-1-i];
            stall_c[STAGES-1-i] = acc;
        end
        if (rst || flush_q) begin
            stall_c = '0;
        end
    end

    // Multi-cycle timer: the start cycle stalls combinationally, the counter
    // covers the remaining mc_cycles-1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_cnt <= '0;
        end else if (flush_q) begin
            mc_cnt <= '0;
        end else if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - CNT_W'(1);
        end else if (mc_accept) begin
            mc_cnt <= bus.mc_cycles - CNT_W'(1);
        end
    end

    // Flush is registered so no combinational path exists from flush_req.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            flush_q <= bus.flush_req;
            if (bus.flush_req) begin
                new_pc_q <= bus.flush_pc;
            end
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall_c[0] && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.stall        = stall_c;
        bus.flush        = flush_q;
        bus.new_pc       = new_pc_q;
        bus.mc_busy      = busy;
        bus.stall_cycles = perf_q;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, so combinational outputs reflect
// the new inputs and registered outputs reflect the preceding rising edge.
// A 4-bit perf counter makes saturation reachable in a short run.
module tb_pipe_hazard_ctrl;
    localparam int unsigned STAGES = 6;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned PERF_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAGES(STAGES), .PC_W(PC_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    pipe_hazard_ctrl #(
        .STAGES(STAGES), .PC_W(PC_W), .CNT_W(CNT_W), .MC_STAGE(3), .PERF_W(PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.stallreq  = '0;
        bus.mc_start  = 1'b0;
        bus.mc_cycles = '0;
        bus.flush_req = 1'b0;
        bus.flush_pc  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        step(); rst = 1'b0; settle();
        chk("rst_stall", 64'(bus.stall), 64'h0);
        chk("rst_flush", 64'(bus.flush), 64'h0);
        chk("rst_new_pc", 64'(bus.new_pc), 64'h0);
        chk("rst_mc_busy", 64'(bus.mc_busy), 64'h0);
        chk("rst_perf", 64'(bus.stall_cycles), 64'h0);

        // 1: ID only -> PC/IF/ID held
        step(); bus.stallreq = 6'b000100; settle();
        chk("id_stall", 64'(bus.stall), 64'h07);
        step(); bus.stallreq = 6'b000000; settle();
        chk("idle_stall", 64'(bus.stall), 64'h00);
        chk("perf_1", 64'(bus.stall_cycles), 64'd1);

        // 2: EX+ID, then WB alone
        step(); bus.stallreq = 6'b001100; settle();
        chk("exid_stall", 64'(bus.stall), 64'h0F);
        step(); bus.stallreq = 6'b100000; settle();
        chk("wb_stall", 64'(bus.stall), 64'h3F);
        chk("perf_2", 64'(bus.stall_cycles), 64'd2);
        step(); bus.stallreq = 6'b000000; settle();
        chk("idle2_stall", 64'(bus.stall), 64'h00);

        // 3: 4-cycle multi-cycle op, re-pulse mid-op ignored
        step(); bus.mc_start = 1'b1; bus.mc_cycles = 6'd4; settle();
        chk("mc_c1_busy", 64'(bus.mc_busy), 64'h1);
        chk("mc_c1_stall", 64'(bus.stall), 64'h0F);
        step(); bus.mc_start = 1'b0; settle();
        chk("mc_c2_stall", 64'(bus.stall), 64'h0F);
        step(); bus.mc_start = 1'b1; bus.mc_cycles = 6'd9; settle();
        chk("mc_c3_stall", 64'(bus.stall), 64'h0F);
        step(); bus.mc_start = 1'b0; settle();
        chk("mc_c4_busy", 64'(bus.mc_busy), 64'h1);
        chk("mc_c4_stall", 64'(bus.stall), 64'h0F);
        step(); settle();
        chk("mc_end_busy", 64'(bus.mc_busy), 64'h0);
        chk("mc_end_stall", 64'(bus.stall), 64'h00);
        chk("perf_7", 64'(bus.stall_cycles), 64'd7);

        // 4: zero-length op
        step(); bus.mc_start = 1'b1; bus.mc_cycles = 6'd0; settle();
        chk("mc0_busy", 64'(bus.mc_busy), 64'h0);
        chk("mc0_stall", 64'(bus.stall), 64'h00);
        step(); bus.mc_start = 1'b0; settle();
        chk("mc0_after_busy", 64'(bus.mc_busy), 64'h0);
        chk("mc0_perf", 64'(bus.stall_cycles), 64'd7);

        // 5: flush with 2 cycles left in a multi-cycle op
        step(); bus.mc_start = 1'b1; bus.mc_cycles = 6'd3; settle();
        chk("fl_mc_busy", 64'(bus.mc_busy), 64'h1);
        step(); bus.mc_start = 1'b0; bus.flush_req = 1'b1; bus.flush_pc = 32'hBFC00380; settle();
        chk("fl_req_noflush", 64'(bus.flush), 64'h0);
        chk("fl_req_stall", 64'(bus.stall), 64'h0F);
        step(); bus.flush_req = 1'b0; bus.flush_pc = 32'h0; settle();
        chk("fl_flush", 64'(bus.flush), 64'h1);
        chk("fl_new_pc", 64'(bus.new_pc), 64'hBFC00380);
        chk("fl_stall", 64'(bus.stall), 64'h00);
        step(); settle();
        chk("fl_after_busy", 64'(bus.mc_busy), 64'h0);
        chk("fl_after_flush", 64'(bus.flush), 64'h0);
        chk("fl_pc_hold", 64'(bus.new_pc), 64'hBFC00380);
        chk("perf_9", 64'(bus.stall_cycles), 64'd9);

        // Back-to-back flush; mc_start and stallreq ignored while flushing
        step(); bus.flush_req = 1'b1; bus.flush_pc = 32'h0000_0100; settle();
        step(); bus.flush_pc = 32'h0000_0200;
        bus.mc_start = 1'b1; bus.mc_cycles = 6'd4; bus.stallreq = 6'b100000; settle();
        chk("b2b_flush1", 64'(bus.flush), 64'h1);
        chk("b2b_pc1", 64'(bus.new_pc), 64'h100);
        chk("b2b_busy", 64'(bus.mc_busy), 64'h0);
        chk("b2b_stall", 64'(bus.stall), 64'h00);
        step(); bus.flush_req = 1'b0; bus.mc_start = 1'b0; bus.stallreq = '0; settle();
        chk("b2b_flush2", 64'(bus.flush), 64'h1);
        chk("b2b_pc2", 64'(bus.new_pc), 64'h200);
        chk("b2b_busy2", 64'(bus.mc_busy), 64'h0);
        step(); settle();
        chk("b2b_done", 64'(bus.flush), 64'h0);
        chk("b2b_perf", 64'(bus.stall_cycles), 64'd9);

        // 6: saturation of the perf counter
        step(); bus.stallreq = 6'b000001; settle();
        chk("pc_only_stall", 64'(bus.stall), 64'h01);
        repeat (10) step();
        settle();
        chk("perf_sat", 64'(bus.stall_cycles), 64'hF);
        step(); settle();
        chk("perf_sat_hold", 64'(bus.stall_cycles), 64'hF);

        // Reset during multi-cycle op with a flush pending
        step(); bus.stallreq = '0; bus.mc_start = 1'b1; bus.mc_cycles = 6'd8; settle();
        step(); bus.mc_start = 1'b0; bus.flush_req = 1'b1; bus.flush_pc = 32'h55; rst = 1'b1; settle();
        step(); rst = 1'b0; bus.flush_req = 1'b0; settle();
        chk("rst2_stall", 64'(bus.stall), 64'h0);
        chk("rst2_flush", 64'(bus.flush), 64'h0);
        chk("rst2_new_pc", 64'(bus.new_pc), 64'h0);
        chk("rst2_busy", 64'(bus.mc_busy), 64'h0);
        chk("rst2_perf", 64'(bus.stall_cycles), 64'h0);
        step(); settle();
        chk("rst2_after_flush", 64'(bus.flush), 64'h0);
        chk("rst2_after_busy", 64'(bus.mc_busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
